// File: rtl/dfi_col_sched.sv
// ============================================================================
// Module   : dfi_col_sched
// Brief    : DFI column-command scheduler. Issues DDR2 READ/WRITE commands
//            under tCCD / tWTR / tRTW spacing, launches BL4 write data at the
//            write latency, schedules rddata_en at the read latency and
//            reassembles two returned DFI beats into one 256-bit response.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dfi_col_sched #(
  parameter int WR_LAT      = 3,
  parameter int RD_LAT      = 4,
  parameter int T_CCD       = 2,
  parameter int T_WTR       = 6,
  parameter int T_RTW       = 4,
  parameter int WFIFO_DEPTH = 4,
  parameter int MAX_RD      = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [2:0]   req_ba,
  input  logic [9:0]   req_col,
  input  logic         req_ap,
  input  logic [255:0] req_wdata,
  input  logic [31:0]  req_wmask,
  output logic         dfi_cke,
  output logic         dfi_cs_n,
  output logic         dfi_ras_n,
  output logic         dfi_cas_n,
  output logic         dfi_we_n,
  output logic         dfi_odt,
  output logic [2:0]   dfi_ba,
  output logic [13:0]  dfi_addr,
  output logic         dfi_wrdata_en,
  output logic [127:0] dfi_wrdata,
  output logic [15:0]  dfi_wrdata_mask,
  output logic         dfi_rddata_en,
  input  logic         dfi_rddata_valid,
  input  logic [127:0] dfi_rddata,
  output logic         rsp_valid,
  output logic [255:0] rsp_data,
  output logic         rd_err
);

  // Spacing counter saturates at the largest turnaround it ever has to prove.
  localparam int SPC_MAX_AB = (T_WTR > T_RTW) ? T_WTR : T_RTW;
  localparam int SPC_MAX    = (SPC_MAX_AB > T_CCD) ? SPC_MAX_AB : T_CCD;
  localparam int SPC_W      = $clog2(SPC_MAX + 1);
  localparam logic [SPC_W-1:0] SPC_SAT = SPC_W'(SPC_MAX);
  localparam logic [SPC_W-1:0] CCD_MIN = SPC_W'(T_CCD);
  localparam logic [SPC_W-1:0] WTR_MIN = SPC_W'(T_WTR);
  localparam logic [SPC_W-1:0] RTW_MIN = SPC_W'(T_RTW);
  localparam logic [SPC_W-1:0] SPC_ONE = SPC_W'(1);

  // Schedule shift registers: bit k is high in the k-th cycle after the
  // command cycle (bit 0 = the command cycle itself).
  localparam int WSR_LEN = WR_LAT + 3;
  localparam int RSR_LEN = RD_LAT + 2;

  localparam int FIFO_AW = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
  localparam int FIFO_CW = $clog2(WFIFO_DEPTH + 1);
  localparam logic [FIFO_AW-1:0] PTR_LAST = FIFO_AW'(WFIFO_DEPTH - 1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [FIFO_CW-1:0] FIFO_FULL = FIFO_CW'(WFIFO_DEPTH);
  localparam logic [FIFO_CW-1:0] FIFO_ONE  = FIFO_CW'(1);

  localparam int OUT_CW = $clog2(MAX_RD + 1);
  localparam logic [OUT_CW-1:0] OUT_MAX = OUT_CW'(MAX_RD);
  localparam logic [OUT_CW-1:0] OUT_ONE = OUT_CW'(1);

  logic [SPC_W-1:0]   since;
  logic               last_wr;
  logic [WSR_LEN-1:0] wr_sr;
  logic [RSR_LEN-1:0] rd_sr;

  logic [255:0]       fifo_data [WFIFO_DEPTH];
  logic [31:0]        fifo_mask [WFIFO_DEPTH];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [FIFO_CW-1:0] fcnt;

  logic [OUT_CW-1:0]  out_cnt;
  logic               beat_hi;
  logic [127:0]       rd_lo;

  logic spc_ok;
  logic fifo_ok;
  logic rd_ok;
  logic accept;
  logic acc_wr;
  logic acc_rd;
  logic wr_pop;

  // The FIFO entry retires on its second beat; that slot may be refilled
  // by a write accepted on the same edge.
  assign wr_pop  = wr_sr[WR_LAT+1];
  assign spc_ok  = (since >= CCD_MIN) &&
                   (req_write ? (last_wr  || (since >= RTW_MIN))
                              : (!last_wr || (since >= WTR_MIN)));
  assign fifo_ok = (fcnt != FIFO_FULL) || wr_pop;
  assign rd_ok   = (out_cnt < OUT_MAX);
  assign req_ready = rst_n && spc_ok && (req_write ? fifo_ok : rd_ok);
  assign accept  = req_valid && req_ready;
  assign acc_wr  = accept && req_write;
  assign acc_rd  = accept && !req_write;

  assign dfi_wrdata_en = wr_sr[WR_LAT] | wr_sr[WR_LAT+1];
  assign dfi_odt       = |wr_sr[WR_LAT+2:WR_LAT-1];
  assign dfi_rddata_en = rd_sr[RD_LAT] | rd_sr[RD_LAT+1];

  // Registered command bus: one command cycle per accepted request, DESELECT otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dfi_cke   <= 1'b0;
      dfi_cs_n  <= 1'b1;
      dfi_ras_n <= 1'b1;
      dfi_cas_n <= 1'b1;
      dfi_we_n  <= 1'b1;
      dfi_ba    <= 3'd0;
      dfi_addr  <= 14'd0;
    end else begin
      dfi_cke <= 1'b1;
      if (accept) begin
        dfi_cs_n  <= 1'b0;
        dfi_ras_n <= 1'b1;
        dfi_cas_n <= 1'b0;
        dfi_we_n  <= !req_write;
        dfi_ba    <= req_ba;
        dfi_addr  <= {3'b000, req_ap, req_col};
      end else begin
        dfi_cs_n  <= 1'b1;
        dfi_ras_n <= 1'b1;
        dfi_cas_n <= 1'b1;
        dfi_we_n  <= 1'b1;
        dfi_ba    <= 3'd0;
        dfi_addr  <= 14'd0;
      end
    end
  end

  // Saturating cycles-since-last-command counter plus direction of that command.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      since   <= SPC_SAT;
      last_wr <= 1'b0;
    end else if (accept) begin
      since   <= SPC_ONE;
      last_wr <= req_write;
    end else if (since != SPC_SAT) begin
      since   <= since + SPC_ONE;
    end
  end

  // Shift-register schedules for the write-data and read-enable windows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_sr <= '0;
      rd_sr <= '0;
    end else begin
      wr_sr <= {wr_sr[WSR_LEN-2:0], acc_wr};
      rd_sr <= {rd_sr[RSR_LEN-2:0], acc_rd};
    end
  end

  // Write FIFO storage; contents are only meaningful while occupancy covers them.
  always_ff @(posedge clk) begin
    if (acc_wr) begin
      fifo_data[wptr] <= req_wdata;
      fifo_mask[wptr] <= req_wmask;
    end
  end

  // Write FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
    end else begin
      if (acc_wr) wptr <= (wptr == PTR_LAST) ? '0 : wptr + PTR_ONE;
      if (wr_pop) rptr <= (rptr == PTR_LAST) ? '0 : rptr + PTR_ONE;
      case ({acc_wr, wr_pop})
        2'b10:   fcnt <= fcnt + FIFO_ONE;
        2'b01:   fcnt <= fcnt - FIFO_ONE;
        default: fcnt <= fcnt;
      endcase
    end
  end

  // Beat selection from the FIFO head; data bus is quiet outside the window.
  always_comb begin
    dfi_wrdata      = 128'd0;
    dfi_wrdata_mask = 16'd0;
    if (wr_sr[WR_LAT]) begin
      dfi_wrdata      = fifo_data[rptr][127:0];
      dfi_wrdata_mask = fifo_mask[rptr][15:0];
    end else if (wr_sr[WR_LAT+1]) begin
      dfi_wrdata      = fifo_data[rptr][255:128];
      dfi_wrdata_mask = fifo_mask[rptr][31:16];
    end
  end

  // Outstanding-read count: up on acceptance, down when the response leaves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else begin
      case ({acc_rd, rsp_valid})
        2'b10:   out_cnt <= out_cnt + OUT_ONE;
        2'b01:   out_cnt <= out_cnt - OUT_ONE;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // Reassemble two returned beats into one response; flag data nobody asked for.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_hi   <= 1'b0;
      rd_lo     <= 128'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 256'd0;
      rd_err    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (dfi_rddata_valid) begin
        if (out_cnt == '0) begin
          rd_err <= 1'b1;
        end else if (!beat_hi) begin
          rd_lo   <= dfi_rddata;
          beat_hi <= 1'b1;
        end else begin
          rsp_data  <= {dfi_rddata, rd_lo};
          rsp_valid <= 1'b1;
          beat_hi   <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dfi_col_sched.sv
// ============================================================================
// Module   : tb_dfi_col_sched
// Brief    : Self-checking bench for dfi_col_sched: table-driven requests,
//            scoreboards for command / write-data / read-response streams,
//            per-cycle window models for odt and rddata_en, and hand-written
//            sequences for turnaround, read back-pressure, rd_err and reset.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dfi_col_sched;

  localparam int WL = 3;
  localparam int RL = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_write = 1'b0;
  logic [2:0]   req_ba = '0;
  logic [9:0]   req_col = '0;
  logic         req_ap = 1'b0;
  logic [255:0] req_wdata = '0;
  logic [31:0]  req_wmask = '0;
  logic         req_ready;
  logic         dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_odt;
  logic [2:0]   dfi_ba;
  logic [13:0]  dfi_addr;
  logic         dfi_wrdata_en;
  logic [127:0] dfi_wrdata;
  logic [15:0]  dfi_wrdata_mask;
  logic         dfi_rddata_en;
  wire          dfi_rddata_valid;
  wire  [127:0] dfi_rddata;
  logic         rsp_valid;
  logic [255:0] rsp_data;
  logic         rd_err;

  logic         d2_ready, d2_cke, d2_cs_n, d2_ras_n, d2_cas_n, d2_we_n, d2_odt;
  logic [2:0]   d2_ba;
  logic [13:0]  d2_addr;
  logic         d2_wen;
  logic [127:0] d2_wdata;
  logic [15:0]  d2_wmask;
  logic         d2_ren, d2_rsp_valid, d2_rd_err;
  logic [255:0] d2_rsp_data;

  always #5 clk = ~clk;

  dfi_col_sched dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_ba(req_ba), .req_col(req_col), .req_ap(req_ap),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .dfi_cke(dfi_cke),
    .dfi_cs_n(dfi_cs_n), .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n),
    .dfi_we_n(dfi_we_n), .dfi_odt(dfi_odt), .dfi_ba(dfi_ba), .dfi_addr(dfi_addr),
    .dfi_wrdata_en(dfi_wrdata_en), .dfi_wrdata(dfi_wrdata),
    .dfi_wrdata_mask(dfi_wrdata_mask), .dfi_rddata_en(dfi_rddata_en),
    .dfi_rddata_valid(dfi_rddata_valid), .dfi_rddata(dfi_rddata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rd_err(rd_err)
  );

  // Shallow-FIFO instance, used only to observe the FIFO-full stall.
  dfi_col_sched #(.WFIFO_DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(d2_ready),
    .req_write(req_write), .req_ba(req_ba), .req_col(req_col), .req_ap(req_ap),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .dfi_cke(d2_cke),
    .dfi_cs_n(d2_cs_n), .dfi_ras_n(d2_ras_n), .dfi_cas_n(d2_cas_n),
    .dfi_we_n(d2_we_n), .dfi_odt(d2_odt), .dfi_ba(d2_ba), .dfi_addr(d2_addr),
    .dfi_wrdata_en(d2_wen), .dfi_wrdata(d2_wdata),
    .dfi_wrdata_mask(d2_wmask), .dfi_rddata_en(d2_ren),
    .dfi_rddata_valid(dfi_rddata_valid), .dfi_rddata(dfi_rddata),
    .rsp_valid(d2_rsp_valid), .rsp_data(d2_rsp_data), .rd_err(d2_rd_err)
  );

  typedef struct { int c; bit wr; logic [2:0] ba; logic [13:0] addr; } cmd_t;
  typedef struct { int c; logic [127:0] d; logic [15:0] m; } wb_t;
  typedef struct { int c; logic [255:0] d; } rsp_t;
  typedef struct {
    bit wr; logic [2:0] ba; logic [9:0] col; bit ap; logic [13:0] exp_addr;
    int idle; int exp_gap; int exp_r2;
  } vec_t;

  cmd_t cmd_q[$];
  wb_t  wb_q[$];
  rsp_t rsp_q[$];
  bit   odt_exp [0:4095];
  bit   rde_exp [0:4095];

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   rd_sent = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: actual %0h required %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_wdata(int idx);
    logic [255:0] d;
    for (int i = 0; i < 32; i++) d[i*8 +: 8] = 8'(i + 32 * idx);
    return d;
  endfunction

  function automatic logic [127:0] pbeat(int k);
    logic [31:0] kk;
    kk = 32'(k);
    return {32'hA000_0000 + kk, 32'hB000_0000 + kk, 32'hC000_0000 + kk, 32'hD000_0000 + kk};
  endfunction

  // PHY model: read data valid two cycles after each rddata_en cycle.
  logic [2:0]   h = '0;
  logic         phy_v = 1'b0;
  logic [127:0] phy_d = '0;
  int           phy_k = 0;
  logic         inject = 1'b0;
  assign dfi_rddata_valid = phy_v | inject;
  assign dfi_rddata       = phy_d;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      h = {h[1:0], dfi_rddata_en};
      phy_v = h[2];
      if (h[2]) begin
        phy_d = pbeat(phy_k);
        phy_k++;
      end else begin
        phy_d = '0;
      end
    end
  end

  // Output monitors: sample mid-cycle, compare against scoreboards and window models.
  cmd_t m_cmd;
  wb_t  m_wb;
  rsp_t m_rsp;
  always @(negedge clk) begin
    if (mon_en) begin
      if (dfi_cs_n == 1'b0) begin
        if (cmd_q.size() == 0) begin
          chk("cmd_unexpected", 1'b1, 1'b0);
        end else begin
          m_cmd = cmd_q.pop_front();
          chk("cmd_cycle", 32'(cyc), 32'(m_cmd.c));
          chk("cmd_code", {dfi_ras_n, dfi_cas_n, dfi_we_n}, {1'b1, 1'b0, !m_cmd.wr});
          chk("cmd_ba", dfi_ba, m_cmd.ba);
          chk("cmd_addr", dfi_addr, m_cmd.addr);
        end
      end else begin
        chk("deselect", {dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_ba, dfi_addr}, {3'b111, 3'd0, 14'd0});
      end
      if (dfi_wrdata_en) begin
        if (wb_q.size() == 0) begin
          chk("wren_unexpected", 1'b1, 1'b0);
        end else begin
          m_wb = wb_q.pop_front();
          chk("wr_cycle", 32'(cyc), 32'(m_wb.c));
          chk("wr_data", dfi_wrdata, m_wb.d);
          chk("wr_mask", dfi_wrdata_mask, m_wb.m);
        end
      end else begin
        chk("wr_idle_bus", {dfi_wrdata, dfi_wrdata_mask}, 144'd0);
      end
      if (cyc < 4096) begin
        chk("odt", dfi_odt, odt_exp[cyc]);
        chk("rddata_en", dfi_rddata_en, rde_exp[cyc]);
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", 1'b1, 1'b0);
        end else begin
          m_rsp = rsp_q.pop_front();
          chk("rsp_cycle", 32'(cyc), 32'(m_rsp.c));
          chk("rsp_data", rsp_data, m_rsp.d);
        end
      end
    end
  end

  // Present one request (called at posedge+1), hold it until accepted, then
  // record what the DUT must do as a result.
  task automatic send(input bit wr, input logic [2:0] ba, input logic [9:0] col,
                      input bit ap, input logic [255:0] wd, input logic [31:0] wm,
                      output int c, output bit r2);
    bit got;
    cmd_t ce;
    wb_t  we;
    rsp_t re;
    got = 1'b0;
    c = -1;
    r2 = 1'b0;
    req_valid = 1'b1; req_write = wr; req_ba = ba; req_col = col; req_ap = ap;
    req_wdata = wd; req_wmask = wm;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        c = cyc + 1;
        r2 = d2_ready;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk("accept_in_time", got, 1'b1);
    if (got) begin
      ce.c = c; ce.wr = wr; ce.ba = ba; ce.addr = {3'b000, ap, col};
      cmd_q.push_back(ce);
      if (wr) begin
        we.c = c + WL;     we.d = wd[127:0];   we.m = wm[15:0];  wb_q.push_back(we);
        we.c = c + WL + 1; we.d = wd[255:128]; we.m = wm[31:16]; wb_q.push_back(we);
        for (int k = c + WL - 1; k <= c + WL + 2; k++) odt_exp[k] = 1'b1;
      end else begin
        rde_exp[c + RL] = 1'b1;
        rde_exp[c + RL + 1] = 1'b1;
        re.c = c + RL + 4;
        re.d = {pbeat(2 * rd_sent + 1), pbeat(2 * rd_sent)};
        rsp_q.push_back(re);
        rd_sent++;
      end
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cmd"}, {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n}, 4'hF);
    chk({tag, "_cke"}, dfi_cke, 1'b0);
    chk({tag, "_ready"}, req_ready, 1'b0);
    chk({tag, "_odt_en"}, {dfi_odt, dfi_wrdata_en, dfi_rddata_en}, 3'b000);
    chk({tag, "_rsp"}, {rsp_valid, rd_err}, 2'b00);
    chk({tag, "_ba_addr"}, {dfi_ba, dfi_addr}, 17'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  vec_t tbl [7];
  int   c, prev_c, c_r, c_w;
  bit   r2, seen;

  initial begin
    tbl[0] = '{1'b1, 3'd2, 10'h155, 1'b1, 14'h0555, 0,  0, -1};
    tbl[1] = '{1'b0, 3'd1, 10'h020, 1'b0, 14'h0020, 10, 0, -1};
    tbl[2] = '{1'b1, 3'd0, 10'h010, 1'b0, 14'h0010, 12, 0,  1};
    tbl[3] = '{1'b1, 3'd3, 10'h3F8, 1'b1, 14'h07F8, 0,  2,  1};
    tbl[4] = '{1'b1, 3'd5, 10'h004, 1'b0, 14'h0004, 0,  2,  0};
    tbl[5] = '{1'b1, 3'd7, 10'h2AA, 1'b0, 14'h02AA, 0,  2, -1};
    tbl[6] = '{1'b0, 3'd6, 10'h155, 1'b0, 14'h0155, 0,  6, -1};

    // Reset values
    req_write = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    chk("reset_wrbus", {dfi_wrdata, dfi_wrdata_mask, rsp_data}, 400'd0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("cke_after_release", dfi_cke, 1'b1);
    chk("ready_after_release", req_ready, 1'b1);
    @(posedge clk); #1;

    // Table-driven requests
    prev_c = -1;
    for (int i = 0; i < 7; i++) begin
      repeat (tbl[i].idle) begin @(posedge clk); #1; end
      send(tbl[i].wr, tbl[i].ba, tbl[i].col, tbl[i].ap, mk_wdata(i),
           32'h1357_9BDF ^ 32'(i), c, r2);
      chk($sformatf("addr_model_v%0d", i), {3'b000, tbl[i].ap, tbl[i].col}, tbl[i].exp_addr);
      if (tbl[i].exp_gap > 0) chk($sformatf("gap_v%0d", i), 32'(c - prev_c), 32'(tbl[i].exp_gap));
      if (tbl[i].exp_r2 >= 0) chk($sformatf("fifo2_ready_v%0d", i), r2, tbl[i].exp_r2[0]);
      prev_c = c;
    end
    repeat (15) begin @(posedge clk); #1; end

    // READ followed by WRITE: read-to-write turnaround
    send(1'b0, 3'd4, 10'h0C0, 1'b0, '0, '0, c_r, r2);
    send(1'b1, 3'd4, 10'h0C8, 1'b0, mk_wdata(7), 32'hFFFF_0001, c_w, r2);
    chk("rtw_gap", 32'(c_w - c_r), 32'd4);
    repeat (12) begin @(posedge clk); #1; end

    // MAX_RD outstanding reads block further reads until a response
    for (int k = 0; k < 4; k++) send(1'b0, 3'(k), 10'h100 + 10'(k), 1'b0, '0, '0, c, r2);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
      else chk("rd_block", req_ready, 1'b0);
    end
    chk("rsp_seen", seen, 1'b1);
    @(negedge clk);
    chk("rd_unblock", req_ready, 1'b1);
    @(posedge clk); #1;
    repeat (20) begin @(posedge clk); #1; end

    // Unexpected read data sets a sticky error
    @(negedge clk);
    chk("rd_err_pre", rd_err, 1'b0);
    @(posedge clk); #1;
    inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    @(negedge clk);
    chk("rd_err_set", rd_err, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rd_err_sticky", rd_err, 1'b1);
    @(posedge clk); #1;

    // Reset one cycle after a WRITE command, before its data window
    send(1'b1, 3'd1, 10'h033, 1'b0, mk_wdata(9), 32'hAAAA_5555, c, r2);
    @(posedge clk); #1;
    wb_q.delete();
    for (int k = c + WL - 1; k <= c + WL + 2; k++) odt_exp[k] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_state("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("cke_after_midrst", dfi_cke, 1'b1);
    @(posedge clk); #1;
    send(1'b0, 3'd2, 10'h044, 1'b0, '0, '0, c, r2);
    repeat (20) begin @(posedge clk); #1; end

    chk("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wb_q.size()), 32'd0);
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
